hs_earom_arbiter: RTL and testbench

// - Shares the 64x8 high-score EAROM (hs_ram) between the game CPU port and the host save/load port.
// - Sequences host load (download) and save (upload) of all 64 bytes; tracks CPU modifications.
// - Raises an autosave request once CPU writes have settled. Sits between the CPU EAROM decode and hs_ram.
// - hs_ram read and write clocks are both tied to clk.

---
 rtl/hs_pkg.sv | 16 +
 rtl/hs_settle_timer.sv | 40 ++++
 rtl/hs_earom_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_hs_earom_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the high-score EAROM arbiter: FSM states and
// EAROM control encodings ({c1, c2}).
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } hs_state_e;

    localparam logic [1:0] CMD_WR   = 2'b00;
    localparam logic [1:0] CMD_ER   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_NONE = 2'b11;

endpackage

// File: rtl/hs_settle_timer.sv
// Settle timer: reloads on every CPU modification and counts down while
// the contents are dirty. Flags the clock on which the count reaches zero.
module hs_settle_timer #(
    parameter logic [23:0] SETTLE_CYCLES = 24'd6_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(32'(SETTLE_CYCLES) + 32'd1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload wins over decrement; hold at zero once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Single-clock expiry flag on the 1 -> 0 transition.
    assign expired_o = en_i && !load_i && (cnt_q == CW'(1));

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hs_earom_arbiter.sv
// Arbitrates the 64x8 high-score EAROM between the CPU and the host
// load/save port, and raises save_req once CPU changes have settled.
module hs_earom_arbiter
    import hs_pkg::*;
#(
    parameter logic [23:0] SETTLE_CYCLES = 24'd6_000_000,
    parameter int          HOST_FIFO     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] cpu_a,
    input  logic [7:0] cpu_din,
    input  logic       cpu_c1,
    input  logic       cpu_c2,
    input  logic       cpu_cs1,
    output logic [7:0] cpu_dout,
    input  logic       host_wr,
    input  logic       host_rd,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_din,
    output logic [7:0] host_dout,
    output logic       host_dout_vld,
    output logic       host_busy,
    output logic       save_req,
    input  logic       save_ack,
    output logic [5:0] ram_a,
    output logic [7:0] ram_din,
    output logic       ram_c1,
    output logic       ram_c2,
    output logic       ram_cs1,
    input  logic [7:0] ram_dout
);

    if (HOST_FIFO != 1) begin : g_bad_fifo
        $error("hs_earom_arbiter: only a single-entry host write hold is implemented");
    end

    hs_state_e  state_q, state_d;
    logic       phase_q, phase_d;
    logic [5:0] ram_a_q, ram_a_d;
    logic [7:0] ram_din_q, ram_din_d;
    logic [1:0] ram_c_q, ram_c_d;
    logic       ram_cs1_q, ram_cs1_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic [7:0] host_dout_q, host_dout_d;
    logic       host_vld_q, host_vld_d;
    logic       hold_vld_q, hold_vld_d;
    logic [5:0] hold_a_q, hold_a_d;
    logic [7:0] hold_din_q, hold_din_d;
    logic       rd_pend_q, rd_pend_d;
    logic [5:0] rd_addr_q, rd_addr_d;
    logic       pend_vld_q, pend_vld_d;
    logic [1:0] pend_c_q, pend_c_d;
    logic [5:0] pend_a_q, pend_a_d;
    logic [7:0] pend_din_q, pend_din_d;
    logic       dirty_q, dirty_d;
    logic       save_req_q, save_req_d;

    logic       cpu_we, tmr_expired;
    logic       cpu_go, hwr_taken, hrd_taken;
    logic [1:0] cpu_cmd, go_c;
    logic [5:0] go_a;
    logic [7:0] go_din;

    assign cpu_cmd = {cpu_c1, cpu_c2};

    hs_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cpu_we),
        .en_i      (dirty_q),
        .expired_o (tmr_expired)
    );

    // Arbitration, read sequencing, hold/pending capture and dirty tracking.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ram_a_d     = ram_a_q;
        ram_din_d   = ram_din_q;
        ram_c_d     = ram_c_q;
        ram_cs1_d   = 1'b0;
        cpu_dout_d  = cpu_dout_q;
        host_dout_d = host_dout_q;
        host_vld_d  = 1'b0;
        hold_vld_d  = hold_vld_q;
        hold_a_d    = hold_a_q;
        hold_din_d  = hold_din_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        pend_vld_d  = pend_vld_q;
        pend_c_d    = pend_c_q;
        pend_a_d    = pend_a_q;
        pend_din_d  = pend_din_q;
        dirty_d     = dirty_q;
        save_req_d  = save_req_q;
        cpu_we      = 1'b0;
        hwr_taken   = 1'b0;
        hrd_taken   = 1'b0;
        // A live strobe takes precedence over a command deferred during a read.
        cpu_go      = cpu_cs1 || pend_vld_q;
        go_c        = cpu_cs1 ? cpu_cmd : pend_c_q;
        go_a        = cpu_cs1 ? cpu_a   : pend_a_q;
        go_din      = cpu_cs1 ? cpu_din : pend_din_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_go) begin
                    pend_vld_d = 1'b0;
                    if (go_c != CMD_NONE) begin
                        ram_cs1_d = 1'b1;
                        ram_a_d   = go_a;
                        ram_din_d = go_din;
                        ram_c_d   = go_c;
                        if (go_c == CMD_RD) begin
                            state_d = CPU_RD;
                            phase_d = 1'b0;
                        end else begin
                            cpu_we = 1'b1;
                        end
                    end
                end else if (hold_vld_q) begin
                    ram_cs1_d  = 1'b1;
                    ram_a_d    = hold_a_q;
                    ram_din_d  = hold_din_q;
                    ram_c_d    = CMD_WR;
                    hold_vld_d = 1'b0;
                end else if (host_wr) begin
                    ram_cs1_d = 1'b1;
                    ram_a_d   = host_addr;
                    ram_din_d = host_din;
                    ram_c_d   = CMD_WR;
                    hwr_taken = 1'b1;
                end else if (host_rd || rd_pend_q) begin
                    ram_cs1_d = 1'b1;
                    ram_a_d   = host_rd ? host_addr : rd_addr_q;
                    ram_c_d   = CMD_RD;
                    rd_pend_d = 1'b0;
                    hrd_taken = host_rd;
                    state_d   = HOST_RD;
                    phase_d   = 1'b0;
                end
            end
            default: begin
                // RAM is busy with a read: defer any CPU command until IDLE.
                if (cpu_cs1 && (cpu_cmd != CMD_NONE)) begin
                    pend_vld_d = 1'b1;
                    pend_c_d   = cpu_cmd;
                    pend_a_d   = cpu_a;
                    pend_din_d = cpu_din;
                end
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = IDLE;
                    if (state_q == CPU_RD) begin
                        cpu_dout_d = ram_dout;
                    end else begin
                        host_dout_d = ram_dout;
                        host_vld_d  = 1'b1;
                    end
                end
            end
        endcase

        if (host_wr && !hwr_taken) begin
            hold_vld_d = 1'b1;
            hold_a_d   = host_addr;
            hold_din_d = host_din;
        end
        if (host_rd && !hrd_taken) begin
            rd_pend_d = 1'b1;
            rd_addr_d = host_addr;
        end

        // A CPU modification outranks a concurrent save_ack.
        if (cpu_we) begin
            dirty_d    = 1'b1;
            save_req_d = 1'b0;
        end else if (save_ack) begin
            dirty_d    = 1'b0;
            save_req_d = 1'b0;
        end else if (tmr_expired) begin
            save_req_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            ram_a_q     <= '0;
            ram_din_q   <= '0;
            ram_c_q     <= '0;
            ram_cs1_q   <= 1'b0;
            cpu_dout_q  <= '0;
            host_dout_q <= '0;
            host_vld_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_a_q    <= '0;
            hold_din_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_c_q    <= '0;
            pend_a_q    <= '0;
            pend_din_q  <= '0;
            dirty_q     <= 1'b0;
            save_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ram_a_q     <= ram_a_d;
            ram_din_q   <= ram_din_d;
            ram_c_q     <= ram_c_d;
            ram_cs1_q   <= ram_cs1_d;
            cpu_dout_q  <= cpu_dout_d;
            host_dout_q <= host_dout_d;
            host_vld_q  <= host_vld_d;
            hold_vld_q  <= hold_vld_d;
            hold_a_q    <= hold_a_d;
            hold_din_q  <= hold_din_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_c_q    <= pend_c_d;
            pend_a_q    <= pend_a_d;
            pend_din_q  <= pend_din_d;
            dirty_q     <= dirty_d;
            save_req_q  <= save_req_d;
        end
    end

    assign ram_a         = ram_a_q;
    assign ram_din       = ram_din_q;
    assign ram_c1        = ram_c_q[1];
    assign ram_c2        = ram_c_q[0];
    assign ram_cs1       = ram_cs1_q;
    assign cpu_dout      = cpu_dout_q;
    assign host_dout     = host_dout_q;
    assign host_dout_vld = host_vld_q;
    assign host_busy     = hold_vld_q;
    assign save_req      = save_req_q;

endmodule

// File: tb/tb_hs_earom_arbiter.sv
// Bench for hs_earom_arbiter with a behavioural 64x8 EAROM model.
module tb_hs_earom_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] cpu_a = '0;
    logic [7:0] cpu_din = '0;
    logic [1:0] cpu_c = 2'b11;
    logic       cpu_cs1 = 1'b0;
    logic [7:0] cpu_dout;
    logic       host_wr = 1'b0;
    logic       host_rd = 1'b0;
    logic [5:0] host_addr = '0;
    logic [7:0] host_din = '0;
    logic [7:0] host_dout;
    logic       host_dout_vld;
    logic       host_busy;
    logic       save_req;
    logic       save_ack = 1'b0;
    logic [5:0] ram_a;
    logic [7:0] ram_din;
    logic       ram_c1, ram_c2, ram_cs1;
    logic [7:0] ram_dout = '0;

    int nchk = 0;
    int nerr = 0;

    hs_earom_arbiter #(.SETTLE_CYCLES(24'd16), .HOST_FIFO(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_c1(cpu_c[1]), .cpu_c2(cpu_c[0]),
        .cpu_cs1(cpu_cs1), .cpu_dout(cpu_dout),
        .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr), .host_din(host_din),
        .host_dout(host_dout), .host_dout_vld(host_dout_vld), .host_busy(host_busy),
        .save_req(save_req), .save_ack(save_ack),
        .ram_a(ram_a), .ram_din(ram_din), .ram_c1(ram_c1), .ram_c2(ram_c2),
        .ram_cs1(ram_cs1), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // EAROM model: registered read, erase clears the byte.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_cs1) begin
            case ({ram_c1, ram_c2})
                2'b00:   mem[ram_a] <= ram_din;
                2'b01:   mem[ram_a] <= 8'h00;
                2'b10:   ram_dout   <= mem[ram_a];
                default: ;
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        cpu_cs1 = 1'b0; cpu_c = 2'b11; host_wr = 1'b0; host_rd = 1'b0; save_ack = 1'b0;
    endtask

    task automatic cpu_cmd(input logic [1:0] c, input logic [5:0] a, input logic [7:0] d);
        cpu_cs1 = 1'b1; cpu_c = c; cpu_a = a; cpu_din = d;
    endtask

    typedef struct {
        logic       cs;   logic [1:0] c;   logic [5:0] a;   logic [7:0] d;
        logic       hwr;  logic       hrd; logic [5:0] ha;  logic [7:0] hd;
        logic       e_cs; logic [1:0] e_c; logic [5:0] e_a; logic [7:0] e_din;
        logic       e_busy; logic e_vld; logic [7:0] e_hdout;
        logic       chk_cpu; logic [7:0] e_cdout;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // cs c a d | hwr hrd ha hd | e_cs e_c e_a e_din | busy vld hdout | chkcpu cdout
        tbl[0]  = '{1'b1, 2'b00, 6'd3, 8'hA5, 1'b1, 1'b0, 6'd4, 8'h5A, 1'b1, 2'b00, 6'd3, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 2'b00, 6'd4, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 2'b10, 6'd4, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 2'b10, 6'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A};
        tbl[6]  = '{1'b1, 2'b10, 6'd3, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 2'b10, 6'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5};
        tbl[9]  = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b1, 6'd4, 8'h00, 1'b1, 2'b10, 6'd4, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 2'b11, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 2'b00, 6'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

        // Reset state
        reset = 1'b1;
        tick(); tick();
        chk("reset_outs",
            {cpu_dout, host_dout, host_dout_vld, host_busy, save_req, ram_a, ram_din, ram_c1, ram_c2, ram_cs1},
            32'h0);
        reset = 1'b0;

        // Host download of 64 bytes, one per clock
        for (int i = 0; i < 64; i++) begin
            host_wr = 1'b1; host_addr = 6'(i); host_din = 8'(i);
            tick();
            chk("dl_cmd", {ram_cs1, ram_c1, ram_c2, ram_a, ram_din}, {1'b1, 2'b00, 6'(i), 8'(i)});
            chk("dl_busy", {31'd0, host_busy}, 32'd0);
            chk("dl_save", {31'd0, save_req}, 32'd0);
        end
        idle();

        // Host readback of addr 5
        host_rd = 1'b1; host_addr = 6'd5;
        tick();
        host_rd = 1'b0;
        chk("hrd_cmd", {ram_cs1, ram_c1, ram_c2, ram_a}, {1'b1, 2'b10, 6'd5});
        tick();
        chk("hrd_wait_vld", {31'd0, host_dout_vld}, 32'd0);
        tick();
        chk("hrd_data", {host_dout_vld, host_dout}, {1'b1, 8'h05});
        tick();
        chk("hrd_vld_pulse", {31'd0, host_dout_vld}, 32'd0);
        chk("hrd_save", {31'd0, save_req}, 32'd0);

        // Collision, CPU readback and host readback vectors
        for (int v = 0; v < 13; v++) begin
            cpu_cs1 = tbl[v].cs; cpu_c = tbl[v].c; cpu_a = tbl[v].a; cpu_din = tbl[v].d;
            host_wr = tbl[v].hwr; host_rd = tbl[v].hrd; host_addr = tbl[v].ha; host_din = tbl[v].hd;
            tick();
            chk($sformatf("vec%0d_cs", v), {31'd0, ram_cs1}, {31'd0, tbl[v].e_cs});
            if (tbl[v].e_cs)
                chk($sformatf("vec%0d_cmd", v), {ram_c1, ram_c2, ram_a}, {tbl[v].e_c, tbl[v].e_a});
            if (tbl[v].e_cs && tbl[v].e_c == 2'b00)
                chk($sformatf("vec%0d_din", v), {24'd0, ram_din}, {24'd0, tbl[v].e_din});
            chk($sformatf("vec%0d_busy", v), {31'd0, host_busy}, {31'd0, tbl[v].e_busy});
            chk($sformatf("vec%0d_vld", v), {31'd0, host_dout_vld}, {31'd0, tbl[v].e_vld});
            if (tbl[v].e_vld)
                chk($sformatf("vec%0d_hdout", v), {24'd0, host_dout}, {24'd0, tbl[v].e_hdout});
            if (tbl[v].chk_cpu)
                chk($sformatf("vec%0d_cdout", v), {24'd0, cpu_dout}, {24'd0, tbl[v].e_cdout});
        end
        idle();

        reset = 1'b1; tick(); reset = 1'b0;

        // CPU erase: save_req after 16 clocks
        cpu_cmd(2'b01, 6'd7, 8'h00);
        tick();
        idle();
        chk("er_cmd", {ram_cs1, ram_c1, ram_c2, ram_a}, {1'b1, 2'b01, 6'd7});
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("er_early", {31'd0, save_req}, 32'd0);
        end
        tick();
        chk("er_save", {31'd0, save_req}, 32'd1);
        tick();
        chk("er_save_hold", {31'd0, save_req}, 32'd1);
        save_ack = 1'b1; tick(); save_ack = 1'b0;
        chk("er_ack", {31'd0, save_req}, 32'd0);

        // Erase then write 10 clocks later: timer restarts from the write
        cpu_cmd(2'b01, 6'd7, 8'h00);
        tick();
        idle();
        for (int k = 1; k < 10; k++) tick();
        cpu_cmd(2'b00, 6'd7, 8'h77);
        tick();
        idle();
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("rw_early", {31'd0, save_req}, 32'd0);
        end
        tick();
        chk("rw_save", {31'd0, save_req}, 32'd1);

        // save_ack together with a CPU write: write wins
        save_ack = 1'b1;
        cpu_cmd(2'b00, 6'd8, 8'h88);
        tick();
        idle();
        chk("ackwr_clear", {31'd0, save_req}, 32'd0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("ackwr_early", {31'd0, save_req}, 32'd0);
        end
        tick();
        chk("ackwr_resave", {31'd0, save_req}, 32'd1);
        save_ack = 1'b1; tick(); save_ack = 1'b0;
        chk("ack_clear", {31'd0, save_req}, 32'd0);
        for (int k = 0; k < 20; k++) tick();
        chk("ack_stays_clear", {31'd0, save_req}, 32'd0);

        // CPU write arriving during a host read is deferred past the capture
        host_rd = 1'b1; host_addr = 6'd5;
        tick();
        host_rd = 1'b0;
        chk("dfr_rd", {ram_cs1, ram_c1, ram_c2, ram_a}, {1'b1, 2'b10, 6'd5});
        cpu_cmd(2'b00, 6'd1, 8'h33);
        tick();
        idle();
        chk("dfr_wait", {30'd0, ram_cs1, host_dout_vld}, 32'd0);
        tick();
        chk("dfr_cap", {ram_cs1, host_dout_vld, host_dout}, {1'b0, 1'b1, 8'h05});
        tick();
        chk("dfr_wr", {ram_cs1, ram_c1, ram_c2, ram_a, ram_din}, {1'b1, 2'b00, 6'd1, 8'h33});
        chk("dfr_vld_off", {31'd0, host_dout_vld}, 32'd0);

        // Reset one clock after a host read command, with a host write racing it
        tick();
        host_rd = 1'b1; host_addr = 6'd6;
        tick();
        host_rd = 1'b0;
        chk("rst_rd_cmd", {ram_cs1, ram_c1, ram_c2, ram_a}, {1'b1, 2'b10, 6'd6});
        reset = 1'b1; host_wr = 1'b1; host_addr = 6'd9; host_din = 8'h99;
        tick();
        reset = 1'b0; host_wr = 1'b0;
        chk("rst_outs2",
            {cpu_dout, host_dout, host_dout_vld, host_busy, save_req, ram_a, ram_din, ram_c1, ram_c2, ram_cs1},
            32'h0);
        tick();
        chk("rst_no_vld", {29'd0, host_dout_vld, host_busy, ram_cs1}, 32'd0);
        tick();
        chk("rst_no_held", {29'd0, host_dout_vld, host_busy, ram_cs1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
